// File: rtl/fft_stage_pipe_if.sv
// rtl/fft_stage_pipe_if.sv - handshake/data bundle for one radix-2 butterfly stage
//
// Purpose : groups the input-pair handshake, the output-pair handshake and the
//           per-pair mode bits of fft_stage_pipe into one interface.
// Signals : i_valid/o_ready      input pair handshake
//           i_a, i_b             complex inputs {re, im}, signed, P_REAL_BITS each half
//           i_scale, i_inverse   per-pair mode bits (divide by 2, conjugate twiddle)
//           o_valid/i_out_ready  output pair handshake
//           o_a, o_b, o_last     butterfly results {re, im}, frame-end marker
// Modports: master = block feeding/consuming the stage, slave = the stage itself.
interface fft_stage_pipe_if #(
  parameter int P_REAL_BITS = 16
);
  logic                       i_valid;
  logic                       o_ready;
  logic [2*P_REAL_BITS-1:0]   i_a;
  logic [2*P_REAL_BITS-1:0]   i_b;
  logic                       i_scale;
  logic                       i_inverse;
  logic                       o_valid;
  logic                       i_out_ready;
  logic [2*P_REAL_BITS-1:0]   o_a;
  logic [2*P_REAL_BITS-1:0]   o_b;
  logic                       o_last;

  modport master (
    output i_valid, i_a, i_b, i_scale, i_inverse, i_out_ready,
    input  o_ready, o_valid, o_a, o_b, o_last
  );

  modport slave (
    input  i_valid, i_a, i_b, i_scale, i_inverse, i_out_ready,
    output o_ready, o_valid, o_a, o_b, o_last
  );
endinterface

// File: rtl/fft_stage_pipe.sv
// rtl/fft_stage_pipe.sv - radix-2 DIT butterfly stage with a 3-register pipeline
//
// Purpose : computes o_a = a + b*W^k, o_b = a - b*W^k for one FFT stage.
//           Stage M registers b*W, stage R the rounded product t, stage O a+/-t.
//           A global stall (o_valid & ~i_out_ready) freezes every register.
// Ports   : CLK        clock
//           RST        synchronous active-low reset
//           bus        fft_stage_pipe_if.slave (pair handshakes, data, mode bits)
// Config  : FFT_STAGE_SAT_EN defined   -> out-of-range results saturate
//           FFT_STAGE_SAT_EN undefined -> out-of-range results wrap
module fft_stage_pipe #(
  parameter int P_REAL_BITS = 16,
  parameter int P_LOG2N     = 5,
  parameter int P_STAGE     = 4,
  parameter int P_FRAC_BITS = 14
) (
  input  logic            CLK,
  input  logic            RST,
  fft_stage_pipe_if.slave bus
);
  localparam int RB       = P_REAL_BITS;
  localparam int PW       = 2*RB+1;
  localparam int BW       = P_LOG2N-1;
  localparam int HALF_N   = 1 << (P_LOG2N-1);
  localparam int TW_SHIFT = P_LOG2N-1-P_STAGE;
  localparam logic [BW-1:0] BEAT_LAST  = BW'(HALF_N-1);
  localparam logic [BW-1:0] STAGE_MASK = BW'((1 << P_STAGE) - 1);
  localparam logic signed [PW-1:0] RND_HALF = PW'(64'sd1 <<< (P_FRAC_BITS-1));

  // Twiddle generator in Q30 integer arithmetic so it folds at elaboration
  // without real-number support. Angles past pi/2 are mirrored
  // (cos(pi-x) = -cos x, sin(pi-x) = sin x) to keep the series short.
  function automatic longint tw_calc(input int k, input bit want_sin);
    longint pi_q30, x, x2, term, s_acc, c_acc, v;
    int     m;
    bit     neg_c;
    pi_q30 = 64'sd3373259426;
    m      = k;
    neg_c  = 1'b0;
    if (4*k > 2*HALF_N) begin
      m     = HALF_N - k;
      neg_c = 1'b1;
    end
    x  = (2*pi_q30*longint'(m)) / longint'(2*HALF_N);
    x2 = (x*x) >>> 30;
    s_acc = 0;
    term  = x;
    for (int i = 1; i <= 12; i++) begin
      s_acc += term;
      term = -(((term*x2) >>> 30) / longint'((2*i)*(2*i+1)));
    end
    c_acc = 0;
    term  = 64'sd1 <<< 30;
    for (int i = 1; i <= 12; i++) begin
      c_acc += term;
      term = -(((term*x2) >>> 30) / longint'((2*i-1)*(2*i)));
    end
    if (neg_c) c_acc = -c_acc;
    v = want_sin ? s_acc : c_acc;
    return (v + (64'sd1 <<< (29-P_FRAC_BITS))) >>> (30-P_FRAC_BITS);
  endfunction

  // Divide by two with round-half-up; one guard bit avoids overflow of v+1.
  function automatic logic signed [RB:0] scale_half(input logic signed [RB:0] v, input logic en);
    logic signed [RB+1:0] w;
    w = (RB+2)'(v) + (RB+2)'(1);
    return en ? (RB+1)'(w >>> 1) : v;
  endfunction

  function automatic logic signed [RB-1:0] reduce(input logic signed [RB:0] v);
`ifdef FFT_STAGE_SAT_EN
    if (v[RB] != v[RB-1])
      return v[RB] ? {1'b1, {(RB-1){1'b0}}} : {1'b0, {(RB-1){1'b1}}};
    return v[RB-1:0];
`else
    return RB'(v);
`endif
  endfunction

  logic signed [RB-1:0] cos_tab [HALF_N];
  logic signed [RB-1:0] sin_tab [HALF_N];

  for (genvar g = 0; g < HALF_N; g++) begin : g_tw
    localparam logic signed [RB-1:0] C_VAL = RB'(tw_calc(g, 1'b0));
    localparam logic signed [RB-1:0] S_VAL = RB'(tw_calc(g, 1'b1));
    assign cos_tab[g] = C_VAL;
    assign sin_tab[g] = S_VAL;
  end

  logic                 stall, accept;
  logic [BW-1:0]        beat_q, beat_d, tw_idx;
  logic signed [RB-1:0] b_re, b_im, w_re;
  logic signed [RB:0]   w_im, a_re, a_im;

  logic                 m_valid_q, m_valid_d, m_scale_q, m_scale_d, m_last_q, m_last_d;
  logic [2*RB-1:0]      m_a_q, m_a_d;
  logic signed [PW-1:0] m_re_q, m_re_d, m_im_q, m_im_d;

  logic                 r_valid_q, r_valid_d, r_scale_q, r_scale_d, r_last_q, r_last_d;
  logic [2*RB-1:0]      r_a_q, r_a_d;
  logic signed [RB:0]   r_re_q, r_re_d, r_im_q, r_im_d;

  logic                 o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [2*RB-1:0]      o_a_q, o_a_d, o_b_q, o_b_d;

  always_comb begin
    stall  = o_valid_q & ~bus.i_out_ready;
    accept = bus.i_valid & ~stall;

    beat_d = beat_q;
    if (accept) beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;

    // Stage M: complex multiply b * W^k at full precision.
    tw_idx = (beat_q & STAGE_MASK) << TW_SHIFT;
    b_re   = bus.i_b[2*RB-1:RB];
    b_im   = bus.i_b[RB-1:0];
    w_re   = cos_tab[tw_idx];
    // W = cos - j*sin for the forward transform; the inverse conjugates it.
    w_im   = bus.i_inverse ? (RB+1)'(sin_tab[tw_idx]) : -((RB+1)'(sin_tab[tw_idx]));

    m_valid_d = accept;
    m_a_d     = bus.i_a;
    m_scale_d = bus.i_scale;
    m_last_d  = (beat_q == BEAT_LAST);
    m_re_d    = PW'(b_re)*PW'(w_re) - PW'(b_im)*PW'(w_im);
    m_im_d    = PW'(b_re)*PW'(w_im) + PW'(b_im)*PW'(w_re);

    // Stage R: round the product back to sample scale.
    r_valid_d = m_valid_q;
    r_a_d     = m_a_q;
    r_scale_d = m_scale_q;
    r_last_d  = m_last_q;
    r_re_d    = (RB+1)'((m_re_q + RND_HALF) >>> P_FRAC_BITS);
    r_im_d    = (RB+1)'((m_im_q + RND_HALF) >>> P_FRAC_BITS);

    // Stage O: butterfly sums, optional halving, reduction to sample width.
    a_re      = (RB+1)'($signed(r_a_q[2*RB-1:RB]));
    a_im      = (RB+1)'($signed(r_a_q[RB-1:0]));
    o_valid_d = r_valid_q;
    o_last_d  = r_valid_q & r_last_q;
    o_a_d     = {reduce(scale_half(a_re + r_re_q, r_scale_q)),
                 reduce(scale_half(a_im + r_im_q, r_scale_q))};
    o_b_d     = {reduce(scale_half(a_re - r_re_q, r_scale_q)),
                 reduce(scale_half(a_im - r_im_q, r_scale_q))};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      beat_q    <= '0;
      m_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_a_q     <= '0;
      o_b_q     <= '0;
    end else if (!stall) begin
      beat_q    <= beat_d;
      m_valid_q <= m_valid_d;
      m_a_q     <= m_a_d;
      m_scale_q <= m_scale_d;
      m_last_q  <= m_last_d;
      m_re_q    <= m_re_d;
      m_im_q    <= m_im_d;
      r_valid_q <= r_valid_d;
      r_a_q     <= r_a_d;
      r_scale_q <= r_scale_d;
      r_last_q  <= r_last_d;
      r_re_q    <= r_re_d;
      r_im_q    <= r_im_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_a_q     <= o_a_d;
      o_b_q     <= o_b_d;
    end
  end

  assign bus.o_ready = ~stall;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_a     = o_a_q;
  assign bus.o_b     = o_b_q;
endmodule

// File: tb/tb_fft_stage_pipe.sv
// tb/tb_fft_stage_pipe.sv - directed self-checking bench for fft_stage_pipe
module tb_fft_stage_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  logic        q_last [$];

  always #5 clk = ~clk;

  fft_stage_pipe_if #(.P_REAL_BITS(16)) bus ();

  fft_stage_pipe #(
    .P_REAL_BITS(16),
    .P_LOG2N    (5),
    .P_STAGE    (4),
    .P_FRAC_BITS(14)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  // Output transfers are recorded when they are committed at the next edge.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_out_ready) begin
      q_a.push_back(bus.o_a);
      q_b.push_back(bus.o_b);
      q_last.push_back(bus.o_last);
    end
  end

  function automatic logic [31:0] pk(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic clear_q();
    q_a.delete();
    q_b.delete();
    q_last.delete();
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_a         = '0;
    bus.i_b         = '0;
    bus.i_scale     = 1'b0;
    bus.i_inverse   = 1'b0;
    bus.i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sc, input logic inv);
    int   n = 0;
    logic ok;
    bus.i_valid   = 1'b1;
    bus.i_a       = a;
    bus.i_b       = b;
    bus.i_scale   = sc;
    bus.i_inverse = inv;
    forever begin
      @(negedge clk);
      ok = bus.o_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout o_ready stuck low for %0d cycles, required 1", n);
        break;
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int c = 0;
    while (q_a.size() < n && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_a         = '0;
    bus.i_b         = '0;
    bus.i_scale     = 1'b0;
    bus.i_inverse   = 1'b0;
    bus.i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last got %b want 0", bus.o_last); end
    checks++; if (bus.o_a !== 32'h0) begin errors++; $display("FAIL reset_o_a got %h want 0", bus.o_a); end
    checks++; if (bus.o_b !== 32'h0) begin errors++; $display("FAIL reset_o_b got %h want 0", bus.o_b); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got %b want 1", bus.o_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.i_valid = 1'b1;
    bus.i_a     = pk(100, 0);
    bus.i_b     = pk(50, 0);
    @(negedge clk);
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL basic_o_ready got %b want 1", bus.o_ready); end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 o_valid got %b want 0", bus.o_valid); end
    @(posedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_latency2 o_valid got %b want 0", bus.o_valid); end
    @(posedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL basic_latency3 o_valid got %b want 1", bus.o_valid); end
    checks++; if (bus.o_a !== pk(150, 0)) begin errors++; $display("FAIL basic_o_a got %h want %h", bus.o_a, pk(150, 0)); end
    checks++; if (bus.o_b !== pk(50, 0)) begin errors++; $display("FAIL basic_o_b got %h want %h", bus.o_b, pk(50, 0)); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL basic_o_last got %b want 0", bus.o_last); end
  endtask

  task automatic test_twiddle();
    do_reset();
    for (int i = 0; i < 8; i++) send(32'h0, 32'h0, 1'b0, 1'b0);
    send(32'h0, pk(0, 64), 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) send(32'h0, 32'h0, 1'b0, 1'b0);
    send(32'h0, pk(0, 64), 1'b0, 1'b1);
    wait_q(25);
    checks++; if (q_a.size() !== 25) begin errors++; $display("FAIL twiddle_count got %0d want 25", q_a.size()); end
    checks++; if (q_a[8] !== pk(64, 0)) begin errors++; $display("FAIL twiddle_fwd_o_a got %h want %h", q_a[8], pk(64, 0)); end
    checks++; if (q_b[8] !== pk(-64, 0)) begin errors++; $display("FAIL twiddle_fwd_o_b got %h want %h", q_b[8], pk(-64, 0)); end
    checks++; if (q_a[24] !== pk(-64, 0)) begin errors++; $display("FAIL twiddle_inv_o_a got %h want %h", q_a[24], pk(-64, 0)); end
    checks++; if (q_b[24] !== pk(64, 0)) begin errors++; $display("FAIL twiddle_inv_o_b got %h want %h", q_b[24], pk(64, 0)); end
    checks++; if (q_last[15] !== 1'b1) begin errors++; $display("FAIL twiddle_last15 got %b want 1", q_last[15]); end
    checks++; if (q_last[8] !== 1'b0) begin errors++; $display("FAIL twiddle_last8 got %b want 0", q_last[8]); end
  endtask

  task automatic test_modes_per_beat();
    do_reset();
    send(pk(101, 0), pk(50, 0), 1'b1, 1'b0);
    send(pk(100, 0), pk(50, 0), 1'b0, 1'b0);
    send(32'h0,      pk(50, 0), 1'b0, 1'b1);
    wait_q(3);
    checks++; if (q_a.size() !== 3) begin errors++; $display("FAIL modes_count got %0d want 3", q_a.size()); end
    checks++; if (q_a[0] !== pk(76, 0)) begin errors++; $display("FAIL modes_scale_o_a got %h want %h", q_a[0], pk(76, 0)); end
    checks++; if (q_b[0] !== pk(26, 0)) begin errors++; $display("FAIL modes_scale_o_b got %h want %h", q_b[0], pk(26, 0)); end
    checks++; if (q_a[1] !== pk(149, -10)) begin errors++; $display("FAIL modes_w1_o_a got %h want %h", q_a[1], pk(149, -10)); end
    checks++; if (q_b[1] !== pk(51, 10)) begin errors++; $display("FAIL modes_w1_o_b got %h want %h", q_b[1], pk(51, 10)); end
    checks++; if (q_a[2] !== pk(46, 19)) begin errors++; $display("FAIL modes_w2inv_o_a got %h want %h", q_a[2], pk(46, 19)); end
    checks++; if (q_b[2] !== pk(-46, -19)) begin errors++; $display("FAIL modes_w2inv_o_b got %h want %h", q_b[2], pk(-46, -19)); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_a;
`ifdef FFT_STAGE_SAT_EN
    exp_a = pk(32767, 0);
`else
    exp_a = pk(-2, 0);
`endif
    do_reset();
    send(pk(32767, 0), pk(32767, 0), 1'b0, 1'b0);
    wait_q(1);
    checks++; if (q_a[0] !== exp_a) begin errors++; $display("FAIL overflow_o_a got %h want %h", q_a[0], exp_a); end
    checks++; if (q_b[0] !== 32'h0) begin errors++; $display("FAIL overflow_o_b got %h want 0", q_b[0]); end
    do_reset();
    send(pk(32767, 0), pk(32767, 0), 1'b1, 1'b0);
    wait_q(1);
    checks++; if (q_a[0] !== pk(32767, 0)) begin errors++; $display("FAIL overflow_scaled_o_a got %h want %h", q_a[0], pk(32767, 0)); end
    checks++; if (q_b[0] !== 32'h0) begin errors++; $display("FAIL overflow_scaled_o_b got %h want 0", q_b[0]); end
  endtask

  task automatic test_backpressure();
    int          stall_n = 0;
    logic [31:0] prev_a, prev_b;
    logic        prev_last;
    do_reset();
    fork
      begin
        for (int i = 0; i < 16; i++) send(pk(i*100+1, -3*i), 32'h0, 1'b0, 1'b0);
      end
      begin
        for (int cyc = 0; cyc < 30; cyc++) begin
          bus.i_out_ready = !(cyc >= 4 && cyc <= 8);
          @(negedge clk);
          if (!bus.i_out_ready && bus.o_valid) begin
            stall_n++;
            checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_o_ready cyc %0d got %b want 0", cyc, bus.o_ready); end
            if (stall_n > 1) begin
              checks++;
              if (bus.o_a !== prev_a || bus.o_b !== prev_b || bus.o_last !== prev_last) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got %h/%h/%b want %h/%h/%b", cyc, bus.o_a, bus.o_b, bus.o_last, prev_a, prev_b, prev_last);
              end
            end
            prev_a    = bus.o_a;
            prev_b    = bus.o_b;
            prev_last = bus.o_last;
          end
          @(posedge clk);
          #1;
        end
        bus.i_out_ready = 1'b1;
      end
    join
    wait_q(16);
    checks++; if (stall_n !== 5) begin errors++; $display("FAIL bp_stall_cycles got %0d want 5", stall_n); end
    checks++; if (q_a.size() !== 16) begin errors++; $display("FAIL bp_count got %0d want 16", q_a.size()); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (q_a[i] !== pk(i*100+1, -3*i)) begin errors++; $display("FAIL bp_o_a[%0d] got %h want %h", i, q_a[i], pk(i*100+1, -3*i)); end
      checks++; if (q_b[i] !== pk(i*100+1, -3*i)) begin errors++; $display("FAIL bp_o_b[%0d] got %h want %h", i, q_b[i], pk(i*100+1, -3*i)); end
      checks++; if (q_last[i] !== (i == 15)) begin errors++; $display("FAIL bp_o_last[%0d] got %b want %b", i, q_last[i], (i == 15)); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 7; i++) send(pk(5, 5), pk(0, 64), 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midrst_o_valid got %b want 0", bus.o_valid); end
    clear_q();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL midrst_o_ready got %b want 1", bus.o_ready); end
    send(32'h0, pk(0, 64), 1'b0, 1'b0);
    wait_q(1);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (q_a.size() !== 1) begin errors++; $display("FAIL midrst_count got %0d want 1", q_a.size()); end
    checks++; if (q_a[0] !== pk(0, 64)) begin errors++; $display("FAIL midrst_o_a got %h want %h", q_a[0], pk(0, 64)); end
    checks++; if (q_b[0] !== pk(0, -64)) begin errors++; $display("FAIL midrst_o_b got %h want %h", q_b[0], pk(0, -64)); end
    checks++; if (q_last[0] !== 1'b0) begin errors++; $display("FAIL midrst_o_last got %b want 0", q_last[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_twiddle();
    test_modes_per_beat();
    test_overflow();
    test_backpressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/fft_stage_pipe.md
FFT_STAGE_PIPE -- requirements
Module: fft_stage_pipe

Interface
- REQ-001 The block SHALL have parameter P_REAL_BITS, default 16, width of each real and imaginary component of a sample.
- REQ-002 The block SHALL have parameter P_LOG2N, default 5, log2 of the FFT length N; the legal range is 2..10.
- REQ-003 The block SHALL have parameter P_STAGE, default 4, the butterfly stage index; the legal range is 0..P_LOG2N-1.
- REQ-004 The block SHALL have parameter P_FRAC_BITS, default 14, the number of twiddle fraction bits; it SHALL be at most P_REAL_BITS-2.
- REQ-005 The block SHALL have the following ports:
  - CLK  in  1  clock.
  - RST  in  1  reset, synchronous, active-low.
  - i_valid  in  1  an input butterfly pair is offered.
  - o_ready  out  1  the stage accepts the pair this cycle.
  - i_a, i_b  in  2*P_REAL_BITS each  complex inputs, real part in the upper half and imaginary part in the lower half, signed two's complement.
  - i_scale  in  1  divide the outputs by 2; sampled with each accepted pair.
  - i_inverse  in  1  use conjugate twiddles (IFFT); sampled with each accepted pair.
  - o_valid  out  1  an output pair is present.
  - i_out_ready  in  1  the downstream block accepts the output pair.
  - o_a, o_b  out  2*P_REAL_BITS each  butterfly results, same packing as the inputs.
  - o_last  out  1  marks the final pair of a frame (beat N/2-1).

Function
- REQ-006 A pair SHALL transfer when i_valid and o_ready are both high on a rising CLK edge.
- REQ-007 An output pair SHALL transfer when o_valid and i_out_ready are both high.
- REQ-008 The datapath SHALL be a 3-register pipeline:
  - stage M registers the complex product b*W;
  - stage R registers the rounded twiddle product t;
  - stage O registers a+t and a-t.
- REQ-009 Latency SHALL be exactly 3 cycles from input transfer to o_valid when the pipeline is not stalled.
- REQ-010 A pipeline stall SHALL occur while o_valid=1 and i_out_ready=0. During a stall every pipeline register, o_a, o_b, o_last and o_valid SHALL hold, and o_ready SHALL be 0.
- REQ-011 When not stalled, o_ready SHALL be 1; the block SHALL sustain one pair per cycle, with bubbles propagating as o_valid=0.
- REQ-012 A beat counter SHALL count accepted pairs from 0 to N/2-1, then wrap to 0. o_last SHALL be 1 on the output of beat N/2-1.
- REQ-013 The twiddle index SHALL be k = (beat mod 2^P_STAGE) << (P_LOG2N-1-P_STAGE).
- REQ-014 Twiddle W^k SHALL equal round(cos(2*pi*k/N)*2^P_FRAC_BITS) - j*round(sin(2*pi*k/N)*2^P_FRAC_BITS). It SHALL be stored in an N/2-entry constant table fixed at elaboration, with entries P_REAL_BITS wide.
- REQ-015 When i_inverse=1, the imaginary sign of W^k SHALL be negated.
- REQ-016 The product SHALL be computed at full precision (2*P_REAL_BITS+1 bits per component). t SHALL equal (product + 2^(P_FRAC_BITS-1)) arithmetically shifted right by P_FRAC_BITS.
- REQ-017 The sums a±t SHALL be formed at P_REAL_BITS+1 bits. When i_scale=1, each sum SHALL be shifted right by 1 with round-half-up.
- REQ-018 The result SHALL then be reduced to P_REAL_BITS as defined in REQ-021.
- REQ-019 i_scale and i_inverse SHALL travel in the pipeline with their pair, so that mode changes between consecutive beats are honoured per beat.

Reset
- REQ-020 When RST=0 at a rising CLK edge, the block SHALL:
  - clear all pipeline valid bits, o_valid, o_last and the beat counter to 0;
  - clear o_a and o_b to 0;
  - set o_ready to 1 on the cycle after RST returns high.
  
  Pairs in flight when RST is asserted mid-frame SHALL be discarded, and the next accepted pair SHALL be beat 0.

Configuration
- REQ-021 Output reduction SHALL depend on macro FFT_STAGE_SAT_EN:
  - when FFT_STAGE_SAT_EN is defined, values outside the signed P_REAL_BITS range SHALL saturate to the nearest limit, -2^(P_REAL_BITS-1) or 2^(P_REAL_BITS-1)-1;
  - when it is undefined, the upper bits SHALL be discarded (two's-complement wrap).

Verification
- REQ-022 Basic butterfly: P_STAGE=4, beat 0, a=(100,0), b=(50,0), i_scale=0 -> exactly 3 cycles later o_a=(150,0), o_b=(50,0).
- REQ-023 Twiddle at beat 8: P_STAGE=4, a=(0,0), b=(0,64), W=(0,-16384).
  - With i_inverse=0 -> o_a=(64,0), o_b=(-64,0).
  - With i_inverse=1 -> o_a=(-64,0), o_b=(64,0).
- REQ-024 Overflow: a=(32767,0), b=(32767,0), beat 0, i_scale=0.
  - With FFT_STAGE_SAT_EN -> o_a=(32767,0).
  - Without it -> o_a=(-2,0).
  - In both cases o_b=(0,0).
  - With i_scale=1 -> o_a=(32767,0) in both builds.
- REQ-025 Backpressure: stream 16 pairs with i_out_ready held low for cycles 4-8 -> o_ready=0 during the stall, outputs held stable, all 16 results delivered in order, o_last only on the 16th.
- REQ-026 Reset mid-frame: pull RST low after 7 accepted pairs -> o_valid=0 the next cycle, no stale output appears, and the next pair uses beat 0 (W=1).
